serial_addsub: RTL and testbench



---
 rtl/serial_addsub.sv | 200 ++++++++++++++++++++
 tb/tb_serial_addsub.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//
// Bit-serial add/subtract sequencer feeding the accumulator register. The
// adder is a single 1-bit full-adder cell with a registered carry. It
// produces one result bit per clock. A request is sampled in IDLE. The
// WIDTH-bit result and its flags appear WIDTH+1 clocks later with a one-cycle
// done pulse.
//
// Subtraction is a + ~b + 1. The inverted b is loaded into the shift
// register, and the carry is seeded with 1.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous, active-high reset
//   start   in   request, sampled only in IDLE
//   sub     in   0 = a+b, 1 = a-b (sampled with start)
//   a, b    in   WIDTH-bit operands (sampled with start)
//   busy    out  high from the start edge through the done cycle
//   done    out  one-cycle pulse, result/flags valid
//   result  out  registered sum/difference, held until the next completion
//   cout    out  final carry (for sub: 1 = no borrow)
//   ovf     out  two's complement overflow
//   zero    out  result == 0
//
// Build option
//   SERIAL_ADDSUB_OVF_EN  when defined, keeps the carry-into-MSB register and
//                         the ovf flag logic. When undefined, ovf is tied to 0.
// -----------------------------------------------------------------------------
module serial_addsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Serial datapath state
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  // Registered outputs
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_zero;

  // Full-adder cell and control decodes
  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic             w_load;
  logic             w_step;

  assign w_s    = r_sa[0] ^ r_sb[0] ^ r_carry;
  assign w_c    = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_carry) | (r_sb[0] & r_carry);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // Next-state / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Serial datapath: operands shift out LSB first and sum bits shift in at
  // the MSB. After WIDTH steps, r_sum holds the full result.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_sa    <= a;
      r_sb    <= sub ? ~b : b;
      r_sum   <= '0;
      r_carry <= sub;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
      r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_carry <= w_c;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Result/flag registers update only on the DONE -> IDLE edge and hold
  // otherwise. busy covers RUN, DONE and the following done cycle. A start
  // sampled on the edge that ends the done cycle keeps busy high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != IDLE) || (r_state == DONE);
      r_done <= (r_state == DONE);
      if (r_state == DONE) begin
        r_result <= r_sum;
        r_cout   <= r_carry;
        r_zero   <= (r_sum == '0);
      end
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  // Signed overflow is carry-into-MSB xor carry-out-of-MSB. The incoming
  // carry is captured on the final step, before that step updates r_carry.
  logic r_cmsb;
  logic r_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmsb <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_step && w_last) begin
        r_cmsb <= r_carry;
      end
      if (r_state == DONE) begin
        r_ovf <= r_carry ^ r_cmsb;
      end
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;
  assign zero   = r_zero;

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
//
// Directed bench for serial_addsub (WIDTH=16). A cycle-level reference model
// predicts busy, done, result and the flags from plain arithmetic on the
// sampled operands. A compare process checks every DUT output against the
// model on each falling edge. The directed sequences also check literal
// expected values and latencies.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

  localparam int unsigned W = 16;
`ifdef SERIAL_ADDSUB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  int checks = 0;
  int errors = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. The operation is counted in clock edges from the
  // accepting edge. The outputs change WIDTH+1 edges later. The next start
  // can be accepted one edge after that.
  // ---------------------------------------------------------------------------
  int           m_cnt = 0;
  logic         exp_busy = 1'b0;
  logic         exp_done = 1'b0;
  logic [W-1:0] exp_result = '0;
  logic         exp_cout = 1'b0;
  logic         exp_ovf = 1'b0;
  logic         exp_zero = 1'b0;
  logic [W-1:0] p_result;
  logic         p_cout;
  logic         p_ovf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt      = 0;
      exp_busy   = 1'b0;
      exp_done   = 1'b0;
      exp_result = '0;
      exp_cout   = 1'b0;
      exp_ovf    = 1'b0;
      exp_zero   = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (m_cnt == W + 2) m_cnt = 0;
      if (m_cnt == 0) begin
        exp_busy = 1'b0;
        if (start) begin
          int sa;
          int sb;
          int sr;
          sa = $signed(a);
          sb = $signed(b);
          if (sub) begin
            p_result = a - b;
            p_cout   = (a >= b);
            sr       = sa - sb;
          end else begin
            p_result = a + b;
            p_cout   = ((32'(a) + 32'(b)) >= 32'h10000);
            sr       = sa + sb;
          end
          p_ovf    = OVF_ON && ((sr > 32767) || (sr < -32768));
          m_cnt    = 1;
          exp_busy = 1'b1;
        end
      end else begin
        m_cnt++;
        if (m_cnt == W + 2) begin
          exp_done   = 1'b1;
          exp_result = p_result;
          exp_cout   = p_cout;
          exp_ovf    = p_ovf;
          exp_zero   = (p_result == '0);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy",   32'(busy),   32'(exp_busy));
    chk("done",   32'(done),   32'(exp_done));
    chk("result", 32'(result), 32'(exp_result));
    chk("cout",   32'(cout),   32'(exp_cout));
    chk("ovf",    32'(ovf),    32'(exp_ovf));
    chk("zero",   32'(zero),   32'(exp_zero));
  end

  // Call at posedge+1. Returns at posedge+1 inside the done cycle. If
  // pulse_at is nonzero, a distracting start is raised that many edges into
  // the run.
  task automatic run_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic isub, input logic [W-1:0] er, input logic ec,
                        input logic eo, input logic ez, input int pulse_at);
    int   lat;
    logic got;
    a     = ia;
    b     = ib;
    sub   = isub;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) got = 1'b1;
      if (pulse_at != 0 && lat == pulse_at) begin
        start = 1'b1;
        a     = 16'h00FF;
        b     = 16'h0001;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({name, "_latency"}, 32'(lat), 32'd17);
    chk({name, "_result"},  32'(result), 32'(er));
    chk({name, "_cout"},    32'(cout), 32'(ec));
    chk({name, "_ovf"},     32'(ovf), 32'(eo));
    chk({name, "_zero"},    32'(zero), 32'(ez));
    chk({name, "_busy"},    32'(busy), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int ndone;
    #1 reset = 1'b1;
    #1;
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags",  {29'd0, cout, ovf, zero}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    run_op("add", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 0);

    // Hold: idle with changing operands and no start
    repeat (20) begin
      @(posedge clk);
      #1;
      a   = W'($urandom);
      b   = W'($urandom);
      sub = 1'($urandom);
    end
    chk("hold_result", 32'(result), 32'h2233);
    chk("hold_busy",   32'(busy),   32'd0);
    chk("hold_done",   32'(done),   32'd0);
    chk("hold_flags",  {29'd0, cout, ovf, zero}, 32'd0);

    run_op("wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0,   1'b1, 0);
    run_op("sovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, OVF_ON, 1'b0, 0);
    run_op("sub",   16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0,   1'b0, 0);
    run_op("subeq", 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0,   1'b1, 0);
    run_op("novf",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, OVF_ON, 1'b0, 0);

    // Start while busy is ignored. The next op begins on the edge that ends
    // the done cycle.
    run_op("busyst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 4);
    run_op("b2b",    16'h1000, 16'h2000, 1'b0, 16'h3000, 1'b0, 1'b0, 1'b0, 0);

    // Reset in the middle of an operation
    a     = 16'h1111;
    b     = 16'h2222;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy",   32'(busy),   32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_flags",  {29'd0, cout, ovf, zero}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("mid_rst_no_done", 32'(ndone), 32'd0);

    run_op("post_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("final_busy", 32'(busy), 32'd0);
    chk("final_done", 32'(done), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
